// File: rtl/lstm_act_unit.sv
// lstm_act_unit: multi-lane tanh/sigmoid activation for the LSTM gates.
// One shared lookup table is stepped serially across lanes by a small FSM.
module lstm_act_unit #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*8-1:0]      out_data,
  output logic                    busy
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

  // Half of the odd-symmetric table: round(128*tanh(k/48)), k = 0..128.
  localparam int unsigned HT [129] = '{
    0,   3,   5,   8,   11,  13,  16,  19,
    21,  24,  26,  29,  31,  34,  36,  39,
    41,  44,  46,  48,  50,  53,  55,  57,
    59,  61,  63,  65,  67,  69,  71,  73,
    75,  76,  78,  80,  81,  83,  84,  86,
    87,  89,  90,  91,  93,  94,  95,  96,
    97,  99,  100, 101, 102, 103, 104, 104,
    105, 106, 107, 108, 109, 109, 110, 111,
    111, 112, 113, 113, 114, 114, 115, 115,
    116, 116, 117, 117, 118, 118, 118, 119,
    119, 120, 120, 120, 120, 121, 121, 121,
    122, 122, 122, 122, 123, 123, 123, 123,
    123, 124, 124, 124, 124, 124, 124, 125,
    125, 125, 125, 125, 125, 125, 125, 126,
    126, 126, 126, 126, 126, 126, 126, 126,
    126, 126, 126, 126, 127, 127, 127, 127,
    127
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic [LANES*DATA_W-1:0]   cap_data;
  logic                      cap_mode;
  logic [DATA_W-1:0]         x;
  logic [7:0]                s8;
  logic [7:0]                addr;
  logic [7:0]                t;

  // T[a] = 128 + h(a-128) above the midpoint, 128 - h(128-a) below it.
  function automatic logic [7:0] lut(input logic [7:0] a);
    logic [7:0] k;
    logic [7:0] h;
    k = a[7] ? {1'b0, a[6:0]} : 8'd128 - a;
    h = 8'(HT[k]);
    return a[7] ? 8'd128 + h : 8'd128 - h;
  endfunction

  always_comb begin
    x    = cap_data[idx*DATA_W +: DATA_W];
    s8   = x[DATA_W-1 -: 8];
    addr = cap_mode ? {~s8[7], s8[7:1]}
                    : {~s8[7], s8[6:0]};
    t    = lut(addr);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      idx       <= '0;
      cap_data  <= '0;
      cap_mode  <= 1'b0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap_data <= in_data;
            cap_mode <= in_mode;
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          out_data[idx*8 +: 8] <= t;
          if (idx == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
